inst_prefetch_queue: RTL and testbench

// - Fetch stage upstream of if_id_register: issues sequential instruction reads to instruction memory,

---
 rtl/inst_prefetch_queue.sv | 148 ++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: a single-outstanding sequential fetcher that fills a small FIFO
// of {instruction, pc} for decode. A redirect flushes the queue and any in-flight fetch.
module inst_prefetch_queue #(
   parameter int unsigned           INST_WIDTH = 16,
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter int unsigned           DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [INST_WIDTH-1:0] mem_resp_data,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   input  logic                  stall,
   output logic                  inst_valid,
   output logic [INST_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [INST_WIDTH-1:0] inst_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [INST_WIDTH-1:0] last_inst;
   logic [ADDR_WIDTH-1:0] last_pc;

   logic                  req_fire;
   logic                  push;
   logic                  pop;

   assign req_fire   = mem_req_valid & mem_req_ready;
   assign push       = (state == WAIT) & mem_resp_valid & ~redirect;
   assign inst_valid = (count != '0);
   assign pop        = inst_valid & ~stall & ~redirect;

   // Head is read straight from its slot; when empty, the last presented value is held.
   assign inst    = inst_valid ? inst_mem[rd_ptr] : last_inst;
   assign inst_pc = inst_valid ? pc_mem[rd_ptr]   : last_pc;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a response always retires the single outstanding fetch, even in a redirect
   // cycle, so the machine never waits for a response that will not come.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_fire) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               state_nxt = IDLE;
            end else if (redirect) begin
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (mem_resp_valid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: request only with space reserved for the response, never in a redirect cycle
   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = fetch_pc;
      if (!reset && (state == IDLE) && (count < FULL_CNT) && !redirect) begin
         mem_req_valid = 1'b1;
      end
   end

   // Fetch pointer, queue storage and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc  <= RESET_PC;
         req_pc    <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         last_inst <= '0;
         last_pc   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            inst_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else begin
         last_inst <= inst;
         last_pc   <= inst_pc;
         if (redirect) begin
            fetch_pc <= redirect_addr;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
               req_pc   <= fetch_pc;
            end
            if (push) begin
               inst_mem[wr_ptr] <= mem_resp_data;
               pc_mem[wr_ptr]   <= req_pc;
               wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
               count <= count + CNT_W'(1);
            end else if (pop && !push) begin
               count <= count - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: a memory model with random latency, and a stream scoreboard
// expecting decode to see pc, pc+1, ... from each restart point with data = pc + 0x100.
module tb_inst_prefetch_queue;

   localparam int unsigned   IW     = 16;
   localparam int unsigned   AW     = 16;
   localparam logic [AW-1:0] RST_PC = 16'h0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_req_valid;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_ready;
   logic          mem_resp_valid;
   logic [IW-1:0] mem_resp_data;
   logic          redirect;
   logic [AW-1:0] redirect_addr;
   logic          stall;
   logic          inst_valid;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_pc;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int lat_min  = 1;
   int lat_max  = 1;
   int last_due = 0;
   int n_acc    = 0;
   int n_pops   = 0;
   int first_acc = -1;
   int first_val = -1;

   logic [AW-1:0] pend_addr[$];
   int            pend_due[$];
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_tail;
   logic [AW-1:0] exp_req;
   logic [IW-1:0] prev_inst;
   logic [AW-1:0] prev_pc;

   always #5 clk = ~clk;

   inst_prefetch_queue #(
      .INST_WIDTH (IW),
      .ADDR_WIDTH (AW),
      .DEPTH      (4),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .redirect       (redirect),
      .redirect_addr  (redirect_addr),
      .stall          (stall),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return a + 16'h0100;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic exp_extend();
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + 16'd1;
      end
   endtask

   task automatic exp_restart(input logic [AW-1:0] a);
      exp_q.delete();
      exp_tail = a;
      exp_extend();
   endtask

   // One clock: memory model presents the oldest due response just after the edge
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = mem_word(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         mem_resp_valid = 1'b0;
         mem_resp_data  = IW'($urandom);
      end
   endtask

   // Monitor / scoreboard, sampled mid-cycle
   always @(negedge clk) begin : mon
      logic [AW-1:0] p;
      int due;
      if (reset) begin
         exp_restart(RST_PC);
         exp_req   = RST_PC;
         first_acc = -1;
         first_val = -1;
         prev_inst = '0;
         prev_pc   = '0;
      end else begin
         if (!inst_valid) begin
            chk("hold_inst", 32'(inst), 32'(prev_inst));
            chk("hold_pc", 32'(inst_pc), 32'(prev_pc));
         end
         if (inst_valid && first_val < 0) first_val = cyc;
         if (redirect) begin
            chk("req_in_redirect_cycle", 32'(mem_req_valid), 32'd0);
            exp_restart(redirect_addr);
            exp_req = redirect_addr;
         end else if (inst_valid && !stall) begin
            if (exp_q.size() < 8) exp_extend();
            p = exp_q.pop_front();
            chk("pop_pc", 32'(inst_pc), 32'(p));
            chk("pop_inst", 32'(inst), 32'(mem_word(p)));
            n_pops++;
         end
         if (mem_req_valid && mem_req_ready) begin
            chk("req_addr", 32'(mem_req_addr), 32'(exp_req));
            exp_req = exp_req + 16'd1;
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(due);
         end
         prev_inst = inst;
         prev_pc   = inst_pc;
      end
   end

   initial begin : main
      int  p0;
      int  a0;
      logic found;
      reset          = 1'b1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      redirect       = 1'b0;
      redirect_addr  = '0;
      stall          = 1'b0;
      repeat (3) step();
      #1;
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", 32'(inst), 32'd0);
      chk("rst_inst_pc", 32'(inst_pc), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);

      // Sequential stream with a 1-cycle memory
      reset         = 1'b0;
      mem_req_ready = 1'b1;
      repeat (10) step();
      chk("first_acc_seen", 32'(first_acc >= 0), 32'd1);
      chk("accept_to_valid_latency", 32'(first_val - first_acc), 32'd2);
      p0 = n_pops;
      repeat (40) step();
      chk("throughput_40cyc", 32'(n_pops - p0), 32'd20);

      // Fill under stall, then drain without refetch
      stall = 1'b1;
      repeat (20) step();
      #1;
      chk("full_req_valid", 32'(mem_req_valid), 32'd0);
      chk("full_inst_valid", 32'(inst_valid), 32'd1);
      chk("full_no_inflight", 32'(pend_due.size()), 32'd0);
      stall         = 1'b0;
      mem_req_ready = 1'b0;
      p0            = n_pops;
      repeat (8) step();
      #1;
      chk("drain_pops", 32'(n_pops - p0), 32'd4);
      chk("drain_empty", 32'(inst_valid), 32'd0);

      // Redirect while waiting; the stale response arrives the next cycle
      lat_min = 2;
      lat_max = 2;
      step();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      redirect      = 1'b1;
      redirect_addr = 16'h0020;
      #1;
      chk("wait_inflight", 32'(pend_due.size()), 32'd1);
      step();
      redirect = 1'b0;
      #1;
      chk("drop_inst_valid", 32'(inst_valid), 32'd0);
      step();
      #1;
      chk("after_drop_inst_valid", 32'(inst_valid), 32'd0);
      chk("after_drop_req_valid", 32'(mem_req_valid), 32'd1);
      chk("after_drop_req_addr", 32'(mem_req_addr), 32'h0020);

      // Redirect coinciding with a response and a pop, three entries queued
      lat_min       = 1;
      lat_max       = 1;
      stall         = 1'b1;
      mem_req_ready = 1'b1;
      a0            = n_acc;
      for (int i = 0; i < 40 && n_acc < a0 + 4; i++) step();
      chk("fill3_reached", 32'(n_acc >= a0 + 4), 32'd1);
      redirect      = 1'b1;
      redirect_addr = 16'h0040;
      stall         = 1'b0;
      #1;
      chk("fill3_valid", 32'(inst_valid), 32'd1);
      step();
      redirect = 1'b0;
      stall    = 1'b1;
      #1;
      chk("redir_resp_empty", 32'(inst_valid), 32'd0);
      chk("redir_resp_req_valid", 32'(mem_req_valid), 32'd1);
      chk("redir_resp_req_addr", 32'(mem_req_addr), 32'h0040);
      stall = 1'b0;
      repeat (10) step();

      // Fetch address wrap
      redirect      = 1'b1;
      redirect_addr = 16'hFFFE;
      step();
      redirect = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         #1;
         if (inst_valid && inst_pc == 16'hFFFF) found = 1'b1;
      end
      chk("wrap_found_ffff", 32'(found), 32'd1);
      chk("wrap_inst", 32'(inst), 32'h00FF);
      chk("wrap_next_req_valid", 32'(mem_req_valid), 32'd1);
      chk("wrap_next_req_addr", 32'(mem_req_addr), 32'h0000);

      // Reset while a fetch is outstanding; its late response must be ignored
      lat_min = 3;
      lat_max = 3;
      step();
      a0 = n_acc;
      for (int i = 0; i < 20 && n_acc == a0; i++) step();
      chk("rst_wait_accepted", 32'(n_acc > a0), 32'd1);
      mem_req_ready = 1'b0;
      reset         = 1'b1;
      #1;
      chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 20 && pend_due.size() > 0; i++) step();
      step();
      step();
      #1;
      chk("stale_ignored", 32'(inst_valid), 32'd0);
      chk("postrst_req_valid", 32'(mem_req_valid), 32'd1);
      chk("postrst_req_addr", 32'(mem_req_addr), 32'(RST_PC));
      mem_req_ready = 1'b1;

      // Randomized traffic
      lat_min = 1;
      lat_max = 4;
      p0      = n_pops;
      for (int i = 0; i < 3000; i++) begin
         step();
         mem_req_ready = ($urandom_range(0, 9) < 7);
         stall         = ($urandom_range(0, 9) < 3);
         redirect      = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 3) == 0) begin
            redirect_addr = 16'hFFFC + AW'($urandom_range(0, 3));
         end else begin
            redirect_addr = AW'($urandom);
         end
      end
      step();
      redirect = 1'b0;
      stall    = 1'b0;
      repeat (5) step();
      chk("random_progress", 32'(n_pops - p0 > 100), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
